// File: rtl/slot_select_if.sv
// Signal bundle between the CPU-side slot bus and the slot_select decoder.
// The bus side drives the master modport; slot_select uses the slave modport.
interface slot_select_if #(
   parameter int NUM_SLOTS = 8
);
   logic                   phase_zero;
   logic [7:0]             bank;
   logic [15:0]            addr;
   logic                   we;
   logic [7:0]             sltromsel;
   logic [8*NUM_SLOTS-1:0] slot_d;
   logic [NUM_SLOTS-1:0]   device_select;
   logic [NUM_SLOTS-1:0]   io_select;
   logic                   io_strobe;
   logic [2:0]             exp_owner;
   logic                   exp_active;
   logic                   slot_we;
   logic                   slot_oe;
   logic [7:0]             slot_dout;

   modport master (
      output phase_zero, bank, addr, we, sltromsel, slot_d,
      input  device_select, io_select, io_strobe, exp_owner, exp_active,
             slot_we, slot_oe, slot_dout
   );

   modport slave (
      input  phase_zero, bank, addr, we, sltromsel, slot_d,
      output device_select, io_select, io_strobe, exp_owner, exp_active,
             slot_we, slot_oe, slot_dout
   );
endinterface

// File: rtl/slot_select.sv
// Apple II slot bus decoder: registered DEVICE_SELECT/IO_SELECT/IOSTROBE strobes and card read mux.
// Define SLOT_EXPROM_EN to compile in the $C800-$CFFF expansion-ROM ownership logic.
module slot_select #(
   parameter logic [7:0] FLOAT_BYTE = 8'hFF,
   parameter int         NUM_SLOTS  = 8
) (
   input logic          clk_sys,
   input logic          reset_n,
   slot_select_if.slave bus
);
   localparam logic [3:0] NS4 = 4'(NUM_SLOTS);

   logic [7:0]           bank;
   logic [15:0]          addr;
   logic [7:0]           sltromsel;
   logic                 in_window;
   logic [2:0]           dev_n, io_n, exp_slot;
   logic                 dev_hit, io_hit, exp_hit, any_hit;
   logic [NUM_SLOTS-1:0] dev_d, dev_q, ios_d, ios_q;
   logic [2:0]           sel_d, sel_q;
   logic                 oe_d, oe_q, we_q;
   logic [7:0]           rd_byte;

   assign bank      = bus.bank;
   assign addr      = bus.addr;
   assign sltromsel = bus.sltromsel;

   assign in_window = (bank == 8'h00) || (bank == 8'h01) || (bank == 8'hE0) || (bank == 8'hE1);
   assign dev_n     = addr[6:4];
   assign io_n      = addr[10:8];

   // Slot 0 and slots at or above NUM_SLOTS never decode; internal-ROM slots are masked by sltromsel.
   assign dev_hit = in_window && (addr[15:8] == 8'hC0) && addr[7] && (dev_n != 3'd0) &&
                    ({1'b0, dev_n} < NS4) && sltromsel[dev_n];
   assign io_hit  = in_window && (addr[15:11] == 5'b11000) && (io_n != 3'd0) &&
                    ({1'b0, io_n} < NS4) && sltromsel[io_n];

`ifdef SLOT_EXPROM_EN
   logic       release_hit, active_d, active_q, strobe_q;
   logic [2:0] owner_d, owner_q;

   assign exp_hit     = in_window && (addr[15:11] == 5'b11001) && active_q;
   assign release_hit = in_window && (addr == 16'hCFFF);
   assign exp_slot    = owner_q;

   // A new IO_SELECT claim wins over a release or a disabled owner in the same bus cycle.
   always_comb begin
      owner_d  = owner_q;
      active_d = active_q;
      if (io_hit) begin
         owner_d  = io_n;
         active_d = 1'b1;
      end else if (release_hit || !sltromsel[owner_q]) begin
         active_d = 1'b0;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         owner_q  <= 3'd0;
         active_q <= 1'b0;
         strobe_q <= 1'b0;
      end else if (bus.phase_zero) begin
         owner_q  <= owner_d;
         active_q <= active_d;
         strobe_q <= exp_hit;
      end
   end

   assign bus.io_strobe  = strobe_q;
   assign bus.exp_owner  = owner_q;
   assign bus.exp_active = active_q;
`else
   assign exp_hit        = 1'b0;
   assign exp_slot       = 3'd0;
   assign bus.io_strobe  = 1'b0;
   assign bus.exp_owner  = 3'd0;
   assign bus.exp_active = 1'b0;
`endif

   always_comb begin
      dev_d = '0;
      ios_d = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         dev_d[i] = dev_hit && (dev_n == 3'(i));
         ios_d[i] = io_hit && (io_n == 3'(i));
      end
   end

   assign any_hit = dev_hit || io_hit || exp_hit;
   assign oe_d    = any_hit && !bus.we;
   assign sel_d   = dev_hit ? dev_n : (io_hit ? io_n : exp_slot);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         dev_q <= '0;
         ios_q <= '0;
         we_q  <= 1'b0;
         oe_q  <= 1'b0;
      end else if (bus.phase_zero) begin
         dev_q <= dev_d;
         ios_q <= ios_d;
         we_q  <= bus.we;
         oe_q  <= oe_d;
      end
   end

   // Slot index is only observed while oe_q is set, so it carries no reset.
   always_ff @(posedge clk_sys) begin
      if (bus.phase_zero) begin
         sel_q <= sel_d;
      end
   end

   always_comb begin
      rd_byte = FLOAT_BYTE;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (sel_q == 3'(i)) rd_byte = bus.slot_d[8*i +: 8];
      end
   end

   assign bus.device_select = dev_q;
   assign bus.io_select     = ios_q;
   assign bus.slot_we       = we_q;
   assign bus.slot_oe       = oe_q;
   assign bus.slot_dout     = oe_q ? rd_byte : FLOAT_BYTE;
endmodule
